apb_slv_mux_reg: RTL and testbench
==================================

Name: apb_slv_mux_reg

Overview:
- Parametrised, registered APB 1-master to N-slave interconnect; next generation of the team's two-slave APB mux (UART slaves).
- Decodes the slave index from master address MSBs and runs a full APB transfer on the selected slave.
- Adds a decode-miss error response and a per-transfer timeout watchdog.
- Sits between the system APB master and the peripheral slaves (UARTs, timers, GPIO).

Parameters:
- PADDR_SIZE, 12, address width (master and slaves).
- PDATA_SIZE, 32, data width.
- SLAVES, 4, number of slave ports (1..16).
- SLV_ADDR_LSB, 8, LSB of the slave-index field in MST_PADDR; index = MST_PADDR[PADDR_SIZE-1:SLV_ADDR_LSB].
- TIMEOUT, 255, access-phase cycles allowed before forced error; 0 disables the watchdog.

Ports:
- PCLK in 1: clock.
- PRESET in 1: synchronous, active-high reset.
- MST_PSEL, MST_PENABLE, MST_PWRITE in 1 each: master control.
- MST_PADDR in PADDR_SIZE: master address.
- MST_PWDATA in PDATA_SIZE: master write data.
- MST_PRDATA out PDATA_SIZE: read data to master.
- MST_PREADY out 1: transfer complete to master.
- MST_PSLVERR out 1: error response to master.
- SLV_PSEL out SLAVES: one-hot slave select.
- SLV_PENABLE, SLV_PWRITE out 1 each: shared slave control.
- SLV_PADDR out PADDR_SIZE: shared, registered slave address.
- SLV_PWDATA out PDATA_SIZE: shared, registered slave write data.
- SLV_PRDATA in SLAVES*PDATA_SIZE: slave i occupies bits [i*PDATA_SIZE +: PDATA_SIZE].
- SLV_PREADY in SLAVES: per-slave ready.
- SLV_PSLVERR in SLAVES: per-slave error.

Behaviour:
- One clock domain; PCLK is the only clock. Reset is synchronous and active-high on PRESET.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0; captured index, address, data and response registers 0.
- FSM states: IDLE, SETUP, ACCESS, RESP, DERR.
- IDLE:
  - MST_PREADY=0.
  - On MST_PSEL & !MST_PENABLE: latch address, wdata, write and index.
  - Index < SLAVES -> SETUP. Otherwise -> DERR.
- SETUP (1 cycle): SLV_PSEL[idx]=1, SLV_PENABLE=0, shared outputs driven from latches -> ACCESS.
- ACCESS:
  - SLV_PSEL[idx]=1, SLV_PENABLE=1; counter increments each cycle.
  - If SLV_PREADY[idx]: capture SLV_PRDATA slice and SLV_PSLVERR[idx] -> RESP.
  - Else if TIMEOUT!=0 and counter == TIMEOUT-1: captured rdata=0, pslverr=1 -> RESP.
  - If PREADY and timeout occur in the same cycle, PREADY wins (slave response used).
- RESP (1 cycle):
  - MST_PREADY=1; MST_PRDATA and MST_PSLVERR from capture regs; slave PSEL/PENABLE=0; counter cleared -> IDLE.
- DERR (1 cycle): MST_PREADY=1, MST_PSLVERR=1, MST_PRDATA=0; no slave selected -> IDLE.
- MST_PRDATA is 0 whenever MST_PREADY=0.
- Latency: zero-wait slave gives the master 2 wait states. Setup edge T0; MST_PREADY high in cycle T3.
- Back-to-back transfers: a master setup in the cycle after RESP is accepted normally (IDLE samples it).
- Master dropping MST_PSEL mid-transfer is a protocol violation. The mux completes the slave transfer, then returns to IDLE; the response is presented for one cycle regardless.
- Reset asserted mid-transfer: at the next edge all slave selects deassert and the FSM enters IDLE. No response is issued.
- SLV_PSEL is never multi-hot; it is all-zero outside SETUP/ACCESS.
- Counter width is $clog2(TIMEOUT+1). The counter never wraps because the timeout fires first.

Optional Feature:
- Macro: APB_SLV_MUX_ERRCNT_EN.
- When defined, adds output ERR_CNT (16 bits).
  - Saturating count of DERR entries plus timeouts; slave-reported PSLVERR is not counted.
  - Cleared by PRESET.
  - Holds at 16'hFFFF.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package apb_slv_mux_pkg contains:
  - state enum (IDLE, SETUP, ACCESS, RESP, DERR);
  - ERRCNT_W=16 constant;
  - function slv_idx(addr) returning the index field.
- One sub-module: apb_slv_mux_tmo. Timeout counter with clear/enable inputs and an expire output, parametrised by TIMEOUT.

Test Plan:
- Zero-wait read, slave 2: MST_PADDR=0x2_04, SLV_PRDATA slice2=0xA5A5_0001 -> SLV_PSEL=4'b0100 for 2 cycles; MST_PREADY at T3 with PRDATA=0xA5A5_0001, PSLVERR=0.
- Write, slave 0, 3 wait states: PWDATA=0x1234 -> SLV_PWDATA=0x1234 held through ACCESS; MST_PREADY one cycle after SLV_PREADY[0].
- Decode miss: SLAVES=4, MST_PADDR=0x5_00 -> no SLV_PSEL; DERR at T1; MST_PREADY=1, PSLVERR=1, PRDATA=0; ERR_CNT=1 if the feature is enabled.
- Timeout: TIMEOUT=8, slave 1 never ready -> ACCESS lasts 8 cycles, then RESP with PSLVERR=1, PRDATA=0; SLV_PSEL drops.
- PRESET raised during ACCESS -> next edge: all outputs 0, FSM IDLE; next transfer completes normally.
- Back-to-back read slave 3 then write slave 1, no idle cycle -> both complete; SLV_PSEL never multi-hot (assertion).

Source files
------------

// File: rtl/apb_slv_mux_pkg.sv
// Shared state encoding, constants and address-decode helper for the APB slave mux.
// Optional error counter (APB_SLV_MUX_ERRCNT_EN) uses ERRCNT_W from here.
package apb_slv_mux_pkg;

  localparam int unsigned ERRCNT_W  = 16;
  localparam int unsigned IDX_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    DERR
  } state_t;

  // Slave-index field: everything above lsb in the (zero-extended) master address.
  function automatic logic [IDX_MAX_W-1:0] slv_idx(input logic [IDX_MAX_W-1:0] addr,
                                                   input int unsigned          lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/apb_slv_mux_tmo.sv
// Access-phase watchdog: counts enabled cycles and flags the last allowed one.
// TIMEOUT of 0 disables the watchdog entirely.
module apb_slv_mux_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CNT_W-1:0] cnt_q;

  // Expiry fires at LAST, so the counter never reaches a wrap point.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (TIMEOUT != 0)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = (TIMEOUT != 0) && en && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/apb_slv_mux_reg.sv
// Registered APB 1-to-N interconnect with decode-miss error and access watchdog.
// Define APB_SLV_MUX_ERRCNT_EN to add the saturating ERR_CNT output.
module apb_slv_mux_reg
  import apb_slv_mux_pkg::*;
#(
  parameter int unsigned PADDR_SIZE   = 12,
  parameter int unsigned PDATA_SIZE   = 32,
  parameter int unsigned SLAVES       = 4,
  parameter int unsigned SLV_ADDR_LSB = 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         MST_PSEL,
  input  logic                         MST_PENABLE,
  input  logic                         MST_PWRITE,
  input  logic [PADDR_SIZE-1:0]        MST_PADDR,
  input  logic [PDATA_SIZE-1:0]        MST_PWDATA,
  output logic [PDATA_SIZE-1:0]        MST_PRDATA,
  output logic                         MST_PREADY,
  output logic                         MST_PSLVERR,
  output logic [SLAVES-1:0]            SLV_PSEL,
  output logic                         SLV_PENABLE,
  output logic                         SLV_PWRITE,
  output logic [PADDR_SIZE-1:0]        SLV_PADDR,
  output logic [PDATA_SIZE-1:0]        SLV_PWDATA,
  input  logic [SLAVES*PDATA_SIZE-1:0] SLV_PRDATA,
  input  logic [SLAVES-1:0]            SLV_PREADY,
  input  logic [SLAVES-1:0]            SLV_PSLVERR
`ifdef APB_SLV_MUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]          ERR_CNT
`endif
);

  localparam int unsigned IDX_W = PADDR_SIZE - SLV_ADDR_LSB;

  state_t                 state_q, state_d;
  logic [IDX_MAX_W-1:0]   idx_full;
  logic [IDX_W-1:0]       idx_in, idx_q, idx_d;
  logic                   hit;
  logic                   lat_en;
  logic [PDATA_SIZE-1:0]  rd_sel;
  logic                   rdy_sel, err_sel;
  logic [PDATA_SIZE-1:0]  cap_rdata;
  logic                   cap_err;
  logic                   tmo_expire_c;
  logic [SLAVES-1:0]      psel_d;
  logic                   penable_d, pready_d, pslverr_d;

  assign idx_full = slv_idx(IDX_MAX_W'(MST_PADDR), SLV_ADDR_LSB);
  assign idx_in   = IDX_W'(idx_full);
  assign hit      = (idx_full < IDX_MAX_W'(SLAVES));

  // Response mux for the latched slave.
  always_comb begin
    rd_sel  = '0;
    rdy_sel = 1'b0;
    err_sel = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_sel  = SLV_PRDATA[i*PDATA_SIZE +: PDATA_SIZE];
        rdy_sel = SLV_PREADY[i];
        err_sel = SLV_PSLVERR[i];
      end
    end
  end

  apb_slv_mux_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (PCLK),
    .rst      (PRESET),
    .clr      (state_q == RESP),
    .en       (state_q == ACCESS),
    .expire_c (tmo_expire_c)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    lat_en    = 1'b0;
    cap_rdata = '0;
    cap_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (MST_PSEL && !MST_PENABLE) begin
          lat_en  = 1'b1;
          state_d = hit ? SETUP : DERR;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (rdy_sel) begin
          state_d   = RESP;
          cap_rdata = rd_sel;
          cap_err   = err_sel;
        end else if (tmo_expire_c) begin
          state_d = RESP;
          cap_err = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      DERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    idx_d  = lat_en ? idx_in : idx_q;
    psel_d = '0;
    if ((state_d == SETUP) || (state_d == ACCESS)) begin
      psel_d = SLAVES'(1) << idx_d;
    end
    penable_d = (state_d == ACCESS);
    pready_d  = (state_d == RESP) || (state_d == DERR);
    pslverr_d = (state_d == RESP) ? cap_err : (state_d == DERR);
  end

  // Request latches double as the shared slave-side outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      idx_q       <= '0;
      SLV_PADDR   <= '0;
      SLV_PWDATA  <= '0;
      SLV_PWRITE  <= 1'b0;
      SLV_PSEL    <= '0;
      SLV_PENABLE <= 1'b0;
      MST_PREADY  <= 1'b0;
      MST_PSLVERR <= 1'b0;
      MST_PRDATA  <= '0;
    end else begin
      if (lat_en) begin
        idx_q      <= idx_in;
        SLV_PADDR  <= MST_PADDR;
        SLV_PWDATA <= MST_PWDATA;
        SLV_PWRITE <= MST_PWRITE;
      end
      SLV_PSEL    <= psel_d;
      SLV_PENABLE <= penable_d;
      MST_PREADY  <= pready_d;
      MST_PSLVERR <= pslverr_d;
      MST_PRDATA  <= cap_rdata;
    end
  end

`ifdef APB_SLV_MUX_ERRCNT_EN
  logic err_inc;

  // Counts mux-generated errors only; slave PSLVERR is passed through uncounted.
  assign err_inc = (lat_en && !hit) ||
                   ((state_q == ACCESS) && !rdy_sel && tmo_expire_c);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ERR_CNT <= '0;
    end else if (err_inc && (ERR_CNT != '1)) begin
      ERR_CNT <= ERR_CNT + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_apb_slv_mux_reg.sv
// Directed self-checking bench for apb_slv_mux_reg (4 slaves, TIMEOUT=8).
module tb_apb_slv_mux_reg;

  logic         PCLK;
  logic         PRESET;
  logic         MST_PSEL, MST_PENABLE, MST_PWRITE;
  logic [11:0]  MST_PADDR;
  logic [31:0]  MST_PWDATA;
  logic [31:0]  MST_PRDATA;
  logic         MST_PREADY, MST_PSLVERR;
  logic [3:0]   SLV_PSEL;
  logic         SLV_PENABLE, SLV_PWRITE;
  logic [11:0]  SLV_PADDR;
  logic [31:0]  SLV_PWDATA;
  logic [127:0] SLV_PRDATA;
  logic [3:0]   SLV_PREADY, SLV_PSLVERR;
`ifdef APB_SLV_MUX_ERRCNT_EN
  logic [15:0]  ERR_CNT;
`endif

  apb_slv_mux_reg #(
    .PADDR_SIZE   (12),
    .PDATA_SIZE   (32),
    .SLAVES       (4),
    .SLV_ADDR_LSB (8),
    .TIMEOUT      (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .MST_PSEL    (MST_PSEL),
    .MST_PENABLE (MST_PENABLE),
    .MST_PWRITE  (MST_PWRITE),
    .MST_PADDR   (MST_PADDR),
    .MST_PWDATA  (MST_PWDATA),
    .MST_PRDATA  (MST_PRDATA),
    .MST_PREADY  (MST_PREADY),
    .MST_PSLVERR (MST_PSLVERR),
    .SLV_PSEL    (SLV_PSEL),
    .SLV_PENABLE (SLV_PENABLE),
    .SLV_PWRITE  (SLV_PWRITE),
    .SLV_PADDR   (SLV_PADDR),
    .SLV_PWDATA  (SLV_PWDATA),
    .SLV_PRDATA  (SLV_PRDATA),
    .SLV_PREADY  (SLV_PREADY),
    .SLV_PSLVERR (SLV_PSLVERR)
`ifdef APB_SLV_MUX_ERRCNT_EN
    ,
    .ERR_CNT     (ERR_CNT)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural slaves: ready after wait_cfg access cycles unless hung.
  int unsigned wait_cfg [4];
  logic [31:0] rdata_cfg [4];
  logic        err_cfg [4];
  logic        hang [4];
  int unsigned acc_cnt;
  logic [31:0] wr_data [4];
  logic [11:0] wr_addr [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      SLV_PREADY[i]          = SLV_PSEL[i] && SLV_PENABLE && !hang[i] && (acc_cnt >= wait_cfg[i]);
      SLV_PSLVERR[i]         = SLV_PSEL[i] && err_cfg[i];
      SLV_PRDATA[i*32 +: 32] = rdata_cfg[i];
    end
  end

  always @(posedge PCLK) begin
    if (PRESET) acc_cnt <= 0;
    else if (SLV_PENABLE && ((SLV_PSEL & ~SLV_PREADY) != 4'b0)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    for (int i = 0; i < 4; i++) begin
      if (SLV_PSEL[i] && SLV_PENABLE && SLV_PREADY[i] && SLV_PWRITE) begin
        wr_data[i] <= SLV_PWDATA;
        wr_addr[i] <= SLV_PADDR;
      end
    end
  end

  // Per-transfer observation of the slave side.
  int          psel_cycles, acc_cycles, pwdata_bad;
  logic [3:0]  psel_seen;
  logic [11:0] acc_addr;
  logic [31:0] exp_pwdata;

  always @(negedge PCLK) begin
    if (!PRESET) begin
      check("psel_onehot", 64'($countones(SLV_PSEL) <= 1), 64'd1);
      if (!MST_PREADY) check("prdata_zero_when_not_ready", 64'(MST_PRDATA), 64'd0);
      if (SLV_PSEL != 4'b0) begin
        psel_cycles++;
        psel_seen = psel_seen | SLV_PSEL;
      end
      if (SLV_PENABLE) begin
        acc_cycles++;
        acc_addr = SLV_PADDR;
        if (SLV_PWDATA !== exp_pwdata) pwdata_bad++;
      end
    end
  end

  logic [31:0] rd;
  logic        err;
  int          lat;

  // One master transfer; lat is the cycle (setup cycle = 0) in which PREADY is seen.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic perr, output int cyc);
    logic done;
    done        = 1'b0;
    rdata       = '0;
    perr        = 1'b0;
    cyc         = 0;
    psel_cycles = 0;
    acc_cycles  = 0;
    pwdata_bad  = 0;
    psel_seen   = 4'b0;
    exp_pwdata  = wd;
    MST_PSEL    = 1'b1;
    MST_PENABLE = 1'b0;
    MST_PWRITE  = wr;
    MST_PADDR   = addr;
    MST_PWDATA  = wd;
    @(posedge PCLK); #1;
    MST_PENABLE = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge PCLK);
      if (MST_PREADY) begin
        done  = 1'b1;
        cyc   = c;
        rdata = MST_PRDATA;
        perr  = MST_PSLVERR;
      end
      @(posedge PCLK); #1;
      if (done) break;
    end
    check("xfer_completed", 64'(done), 64'd1);
    MST_PSEL    = 1'b0;
    MST_PENABLE = 1'b0;
    MST_PWRITE  = 1'b0;
    MST_PADDR   = '0;
    MST_PWDATA  = '0;
  endtask

  initial begin
    MST_PSEL = 1'b0; MST_PENABLE = 1'b0; MST_PWRITE = 1'b0;
    MST_PADDR = '0; MST_PWDATA = '0;
    exp_pwdata = '0; psel_seen = '0; acc_addr = '0;
    psel_cycles = 0; acc_cycles = 0; pwdata_bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0; rdata_cfg[i] = 32'h1111_1111 * (i + 1);
      err_cfg[i] = 1'b0; hang[i] = 1'b0; wr_data[i] = '0; wr_addr[i] = '0;
    end
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset state
    @(negedge PCLK);
    check("rst_pready",  64'(MST_PREADY),  64'd0);
    check("rst_pslverr", 64'(MST_PSLVERR), 64'd0);
    check("rst_prdata",  64'(MST_PRDATA),  64'd0);
    check("rst_psel",    64'(SLV_PSEL),    64'd0);
    check("rst_penable", 64'(SLV_PENABLE), 64'd0);
    check("rst_pwrite",  64'(SLV_PWRITE),  64'd0);
    check("rst_paddr",   64'(SLV_PADDR),   64'd0);
    check("rst_pwdata",  64'(SLV_PWDATA),  64'd0);
`ifdef APB_SLV_MUX_ERRCNT_EN
    check("rst_errcnt",  64'(ERR_CNT),     64'd0);
`endif
    @(posedge PCLK); #1;

    // Zero-wait read from slave 2
    rdata_cfg[2] = 32'hA5A5_0001;
    apb_xfer(1'b0, 12'h204, 32'h0, rd, err, lat);
    check("rd2_data",  64'(rd),          64'hA5A5_0001);
    check("rd2_err",   64'(err),         64'd0);
    check("rd2_lat",   64'(lat),         64'd3);
    check("rd2_psel",  64'(psel_seen),   64'h4);
    check("rd2_pselc", 64'(psel_cycles), 64'd2);
    check("rd2_accc",  64'(acc_cycles),  64'd1);
    check("rd2_addr",  64'(acc_addr),    64'h204);

    // Write to slave 0 with 3 wait states
    wait_cfg[0] = 3;
    apb_xfer(1'b1, 12'h010, 32'h0000_1234, rd, err, lat);
    check("wr0_err",    64'(err),         64'd0);
    check("wr0_lat",    64'(lat),         64'd6);
    check("wr0_accc",   64'(acc_cycles),  64'd4);
    check("wr0_pselc",  64'(psel_cycles), 64'd5);
    check("wr0_psel",   64'(psel_seen),   64'h1);
    check("wr0_pwdata", 64'(pwdata_bad),  64'd0);
    check("wr0_data",   64'(wr_data[0]),  64'h1234);
    check("wr0_addr",   64'(wr_addr[0]),  64'h010);

    // Decode miss
    apb_xfer(1'b0, 12'h500, 32'h0, rd, err, lat);
    check("miss_lat",   64'(lat),         64'd1);
    check("miss_err",   64'(err),         64'd1);
    check("miss_data",  64'(rd),          64'd0);
    check("miss_pselc", 64'(psel_cycles), 64'd0);
`ifdef APB_SLV_MUX_ERRCNT_EN
    check("miss_errcnt", 64'(ERR_CNT), 64'd1);
`endif

    // Watchdog on a hung slave 1
    hang[1] = 1'b1;
    rdata_cfg[1] = 32'hDEAD_BEEF;
    apb_xfer(1'b0, 12'h100, 32'h0, rd, err, lat);
    check("tmo_accc",  64'(acc_cycles),  64'd8);
    check("tmo_lat",   64'(lat),         64'd10);
    check("tmo_err",   64'(err),         64'd1);
    check("tmo_data",  64'(rd),          64'd0);
    check("tmo_psel",  64'(psel_seen),   64'h2);
    check("tmo_pselc", 64'(psel_cycles), 64'd9);
    check("tmo_drop",  64'(SLV_PSEL),    64'd0);
`ifdef APB_SLV_MUX_ERRCNT_EN
    check("tmo_errcnt", 64'(ERR_CNT), 64'd2);
`endif

    // Slave-reported error passes through
    err_cfg[3] = 1'b1;
    rdata_cfg[3] = 32'h0BAD_0003;
    apb_xfer(1'b0, 12'h3FC, 32'h0, rd, err, lat);
    check("serr_data", 64'(rd),  64'h0BAD_0003);
    check("serr_err",  64'(err), 64'd1);
    check("serr_lat",  64'(lat), 64'd3);
`ifdef APB_SLV_MUX_ERRCNT_EN
    check("serr_errcnt", 64'(ERR_CNT), 64'd2);
`endif

    // Reset during ACCESS
    MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PWRITE = 1'b1;
    MST_PADDR = 12'h120; MST_PWDATA = 32'h5555;
    exp_pwdata = 32'h5555;
    @(posedge PCLK); #1;
    MST_PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_in_access", 64'(SLV_PENABLE), 64'd1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    MST_PSEL = 1'b0; MST_PENABLE = 1'b0; MST_PWRITE = 1'b0;
    MST_PADDR = '0; MST_PWDATA = '0;
    @(negedge PCLK);
    check("mid_psel",    64'(SLV_PSEL),    64'd0);
    check("mid_penable", 64'(SLV_PENABLE), 64'd0);
    check("mid_pready",  64'(MST_PREADY),  64'd0);
    check("mid_pslverr", 64'(MST_PSLVERR), 64'd0);
    check("mid_paddr",   64'(SLV_PADDR),   64'd0);
    check("mid_pwdata",  64'(SLV_PWDATA),  64'd0);
`ifdef APB_SLV_MUX_ERRCNT_EN
    check("mid_errcnt",  64'(ERR_CNT),     64'd0);
`endif
    hang[1] = 1'b0;
    @(posedge PCLK); #1;
    apb_xfer(1'b0, 12'h204, 32'h0, rd, err, lat);
    check("post_rst_data", 64'(rd),  64'hA5A5_0001);
    check("post_rst_err",  64'(err), 64'd0);
    check("post_rst_lat",  64'(lat), 64'd3);

    // Back-to-back: read slave 3 then write slave 1 with no idle cycle
    err_cfg[3]   = 1'b0;
    wait_cfg[3]  = 1;
    rdata_cfg[3] = 32'h3333_0003;
    apb_xfer(1'b0, 12'h3C0, 32'h0, rd, err, lat);
    check("b2b_rd_data", 64'(rd),        64'h3333_0003);
    check("b2b_rd_err",  64'(err),       64'd0);
    check("b2b_rd_lat",  64'(lat),       64'd4);
    check("b2b_rd_psel", 64'(psel_seen), 64'h8);
    apb_xfer(1'b1, 12'h1A0, 32'hCAFE_0001, rd, err, lat);
    check("b2b_wr_err",  64'(err),        64'd0);
    check("b2b_wr_lat",  64'(lat),        64'd3);
    check("b2b_wr_psel", 64'(psel_seen),  64'h2);
    check("b2b_wr_data", 64'(wr_data[1]), 64'hCAFE_0001);
    check("b2b_wr_addr", 64'(wr_addr[1]), 64'h1A0);

    repeat (2) @(posedge PCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
